constraint_sample_engine: RTL and testbench

- Upstream driver for a combinational constraint checker, such as a split_N module exposing a single satisfied flag x.
- Generates pseudo-random packed candidate assignments from a 32-bit Galois LFSR and presents them on cand_o.
- Samples the checker's sat_i result and pushes satisfying candidates out through a valid/ready solution port.
- Runs until a target hit count or a try budget is reached.

---
 rtl/constraint_sample_engine_pkg.sv | 13 +
 rtl/constraint_sample_engine_if.sv | 11 +
 rtl/constraint_sample_engine_lfsr.sv | 26 ++
 rtl/constraint_sample_engine.sv | 161 ++++++++++++++++
 tb/tb_constraint_sample_engine.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/constraint_sample_engine_pkg.sv
// rtl/constraint_sample_engine_pkg.sv - shared types, LFSR constants and sizing helper
package cse_pkg;

   localparam int          LFSR_W    = 32;
   localparam logic [31:0] LFSR_POLY = 32'h80200003;

   typedef enum logic [2:0] {IDLE, FILL, CHECK, PUSH, DONE} state_t;

   function automatic int nwords(input int cand_w);
      return (cand_w + LFSR_W - 1) / LFSR_W;
   endfunction

endpackage

// File: rtl/constraint_sample_engine_if.sv
// rtl/constraint_sample_engine_if.sv - valid/ready solution port
interface constraint_sample_engine_if #(
   parameter int CAND_W = 311
);
   logic              sol_valid_o;
   logic              sol_ready_i;
   logic [CAND_W-1:0] sol_data_o;

   modport master (output sol_valid_o, output sol_data_o, input sol_ready_i);
   modport slave  (input sol_valid_o, input sol_data_o, output sol_ready_i);
endinterface

// File: rtl/constraint_sample_engine_lfsr.sv
// rtl/constraint_sample_engine_lfsr.sv - 32-bit Galois LFSR with seed load and zero-seed fixup
module cse_lfsr32
   import cse_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              step,
   output logic [LFSR_W-1:0] state,
   output logic [LFSR_W-1:0] next_state
);

   // next_state is the value the shift register consumes on the same step
   assign next_state = {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_POLY : '0);

   always_ff @(posedge clk) begin
      if (rst)
         state <= LFSR_W'(1);
      else if (load)
         state <= (seed == '0) ? LFSR_W'(1) : seed;
      else if (step)
         state <= next_state;
   end

endmodule

// File: rtl/constraint_sample_engine.sv
// rtl/constraint_sample_engine.sv - random candidate generator and solution pusher; CSE_STATS_EN adds stall counter
module constraint_sample_engine
   import cse_pkg::*;
#(
   parameter int CAND_W = 311,
   parameter int CNT_W  = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [31:0]       seed_i,
   input  logic [CNT_W-1:0]  target_i,
   input  logic [31:0]       max_tries_i,
   output logic [CAND_W-1:0] cand_o,
   input  logic              sat_i,
   constraint_sample_engine_if.master sol,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  hits_o,
   output logic [31:0]       tries_o
`ifdef CSE_STATS_EN
   ,
   output logic [31:0]       stall_cycles_o
`endif
);

   localparam int NWORDS = nwords(CAND_W);
   localparam int WC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   state_t            state;
   logic [CAND_W-1:0] cand_r;
   logic [WC_W-1:0]   word_cnt;
   logic [CNT_W-1:0]  target_r;
   logic [31:0]       budget_r;
   logic [CNT_W-1:0]  hits_r;
   logic [31:0]       tries_r;
   logic              sol_valid_r;
   logic              busy_r;
   logic              done_r;
   logic [31:0]       lfsr_state;
   logic [31:0]       lfsr_next;
   logic              start_ok;

   assign start_ok = start_i && !abort_i && (state == IDLE || state == DONE);

   cse_lfsr32 u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .load       (start_ok),
      .seed       (seed_i),
      .step       ((state == FILL) && !abort_i),
      .state      (lfsr_state),
      .next_state (lfsr_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cand_r      <= '0;
         word_cnt    <= '0;
         target_r    <= '0;
         budget_r    <= '0;
         hits_r      <= '0;
         tries_r     <= '0;
         sol_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else if (abort_i) begin
         // counters and LFSR keep their values for readback
         state       <= IDLE;
         sol_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  target_r <= target_i;
                  budget_r <= max_tries_i;
                  hits_r   <= '0;
                  tries_r  <= '0;
                  word_cnt <= '0;
                  if (target_i == '0 || max_tries_i == '0) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end else begin
                     state  <= FILL;
                     busy_r <= 1'b1;
                     done_r <= 1'b0;
                  end
               end
            end
            FILL: begin
               cand_r   <= {cand_r[CAND_W-33:0], lfsr_next};
               word_cnt <= word_cnt + WC_W'(1);
               if (word_cnt == WC_W'(NWORDS - 1))
                  state <= CHECK;
            end
            CHECK: begin
               tries_r  <= tries_r + 32'd1;
               word_cnt <= '0;
               if (sat_i) begin
                  state       <= PUSH;
                  sol_valid_r <= 1'b1;
               end else if (tries_r + 32'd1 == budget_r) begin
                  state  <= DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end else begin
                  state <= FILL;
               end
            end
            PUSH: begin
               if (sol.sol_ready_i) begin
                  hits_r      <= hits_r + CNT_W'(1);
                  sol_valid_r <= 1'b0;
                  if (hits_r + CNT_W'(1) == target_r || tries_r == budget_r) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef CSE_STATS_EN
   logic [31:0] stall_r;

   always_ff @(posedge clk) begin
      if (rst)
         stall_r <= '0;
      else if (start_ok)
         stall_r <= '0;
      else if (state == PUSH && !sol.sol_ready_i && stall_r != '1)
         stall_r <= stall_r + 32'd1;
   end

   assign stall_cycles_o = stall_r;
`endif

   assign cand_o          = cand_r;
   assign sol.sol_data_o  = cand_r;
   assign sol.sol_valid_o = sol_valid_r;
   assign busy_o          = busy_r;
   assign done_o          = done_r;
   assign hits_o          = hits_r;
   assign tries_o         = tries_r;

endmodule

// File: tb/tb_constraint_sample_engine.sv
// tb/tb_constraint_sample_engine.sv - self-checking bench for constraint_sample_engine
module tb_constraint_sample_engine;

   localparam int CW    = 64;
   localparam int CNT_W = 16;
   localparam int NW    = (CW + 31) / 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic             abort_i;
   logic [31:0]      seed_i;
   logic [CNT_W-1:0] target_i;
   logic [31:0]      max_tries_i;
   logic [CW-1:0]    cand_o;
   logic             sat_i;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] hits_o;
   logic [31:0]      tries_o;
`ifdef CSE_STATS_EN
   logic [31:0]      stall_cycles_o;
`endif

   int sat_mode;
   int errors = 0;
   int checks = 0;

   logic [CW-1:0] exp_sol[$];
   int            exp_tries;
   int            exp_hits;

   constraint_sample_engine_if #(.CAND_W(CW)) sol ();

   function automatic logic [31:0] lstep(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
   endfunction

   function automatic logic pred(input logic [CW-1:0] c);
      return c[1:0] == 2'b00;
   endfunction

   assign sat_i = (sat_mode == 1) ? 1'b1 : (sat_mode == 2) ? pred(cand_o) : 1'b0;

   constraint_sample_engine #(.CAND_W(CW), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .seed_i         (seed_i),
      .target_i       (target_i),
      .max_tries_i    (max_tries_i),
      .cand_o         (cand_o),
      .sat_i          (sat_i),
      .sol            (sol),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .hits_o         (hits_o),
`ifdef CSE_STATS_EN
      .stall_cycles_o (stall_cycles_o),
`endif
      .tries_o        (tries_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Whole-run reference: candidates are successive LFSR words, tries/hits from the run rules
   task automatic model_run(input logic [31:0] seed, input int target, input int budget, input int mode);
      logic [31:0]   s;
      logic [CW-1:0] c;
      logic          sat;
      exp_sol.delete();
      exp_tries = 0;
      exp_hits  = 0;
      s = (seed == 32'h0) ? 32'h1 : seed;
      if (target == 0 || budget == 0) return;
      forever begin
         c = '0;
         for (int w = 0; w < NW; w++) begin
            s = lstep(s);
            c = (c << 32) | CW'(s);
         end
         exp_tries++;
         sat = (mode == 1) || (mode == 2 && pred(c));
         if (sat) begin
            exp_sol.push_back(c);
            exp_hits++;
            if (exp_hits == target) break;
         end
         if (exp_tries == budget) break;
      end
   endtask

   task automatic do_start(input logic [31:0] seed, input int target, input int budget);
      seed_i      = seed;
      target_i    = CNT_W'(target);
      max_tries_i = budget;
      start_i     = 1'b1;
      step();
      start_i     = 1'b0;
   endtask

   task automatic run_checked(input string name, input int rmode, input int bound, output int cyc);
      int            pushes;
      logic [CW-1:0] held;
      logic          stalled;
      pushes  = 0;
      cyc     = 1;
      stalled = 1'b0;
      while (!done_o && cyc < bound) begin
         if (stalled) begin
            check({name, " valid held"}, sol.sol_valid_o, 1'b1);
            check({name, " data held"}, sol.sol_data_o, held);
         end
         stalled = 1'b0;
         if (sol.sol_valid_o) begin
            sol.sol_ready_i = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (sol.sol_ready_i) begin
               if (exp_sol.size() == 0)
                  check({name, " extra solution"}, pushes + 1, exp_hits);
               else
                  check({name, " sol data"}, sol.sol_data_o, exp_sol.pop_front());
               pushes++;
            end else begin
               stalled = 1'b1;
               held    = sol.sol_data_o;
            end
         end else begin
            sol.sol_ready_i = 1'b0;
         end
         step();
         cyc++;
      end
      sol.sol_ready_i = 1'b0;
      check({name, " done"}, done_o, 1'b1);
      check({name, " hits"}, hits_o, exp_hits);
      check({name, " tries"}, tries_o, exp_tries);
      check({name, " handshakes"}, pushes, exp_hits);
   endtask

   typedef struct {
      logic [31:0] seed;
      int          target;
      int          budget;
      int          mode;
      int          cycles;
      int          tries;
      int          hits;
   } vec_t;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t          tbl[6];
      logic [CW-1:0] exp_c;
      int            cyc;
      int            n;

      tbl[0] = '{32'h1,    3, 5,  0, 5 * (NW + 1) + 1,     5, 0};
      tbl[1] = '{32'h1234, 0, 9,  1, 1,                    0, 0};
      tbl[2] = '{32'h55,   4, 0,  1, 1,                    0, 0};
      tbl[3] = '{32'h9,    2, 10, 1, 2 * (NW + 2) + 1,     2, 2};
      tbl[4] = '{32'h9,    3, 2,  1, 2 * (NW + 2) + 1,     2, 2};
      tbl[5] = '{32'hABCD, 1, 1,  0, (NW + 1) + 1,         1, 0};

      rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; seed_i = '0; target_i = '0;
      max_tries_i = '0; sat_mode = 0; sol.sol_ready_i = 1'b0;
      step();
      step();
      check("reset cand", cand_o, 64'h0);
      check("reset hits", hits_o, 0);
      check("reset tries", tries_o, 0);
      check("reset valid", sol.sol_valid_o, 1'b0);
      check("reset busy", busy_o, 1'b0);
      check("reset done", done_o, 1'b0);
      rst = 1'b0;
      step();

      // LFSR word order, then zero seed behaving like seed 1
      exp_c = {32'h80200003, lstep(32'h80200003)};
      for (int k = 0; k < 2; k++) begin
         sat_mode = 0;
         do_start((k == 0) ? 32'h1 : 32'h0, 1, 5);
         step();
         check("lfsr first word", cand_o[31:0], 32'h80200003);
         step();
         check("lfsr candidate", cand_o, exp_c);
         step();
         check("lfsr tries", tries_o, 1);
         abort_i = 1'b1;
         step();
         abort_i = 1'b0;
         check("lfsr abort busy", busy_o, 1'b0);
      end

      for (int i = 0; i < 6; i++) begin
         sat_mode = tbl[i].mode;
         model_run(tbl[i].seed, tbl[i].target, tbl[i].budget, tbl[i].mode);
         do_start(tbl[i].seed, tbl[i].target, tbl[i].budget);
         check($sformatf("vec%0d busy after start", i), busy_o, tbl[i].cycles > 1);
         check($sformatf("vec%0d done after start", i), done_o, tbl[i].cycles == 1);
         run_checked($sformatf("vec%0d", i), 0, 200, cyc);
         check($sformatf("vec%0d cycles", i), cyc, tbl[i].cycles);
         check($sformatf("vec%0d table tries", i), tries_o, tbl[i].tries);
         check($sformatf("vec%0d table hits", i), hits_o, tbl[i].hits);
      end

      // Backpressure: four stalled cycles per solution
      sat_mode = 1;
      model_run(32'h7, 2, 10, 1);
      do_start(32'h7, 2, 10);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         while (!sol.sol_valid_o && n < 20) begin step(); n++; end
         check("bp valid seen", sol.sol_valid_o, 1'b1);
         for (int j = 0; j < 4; j++) begin
            check("bp stall valid", sol.sol_valid_o, 1'b1);
            check("bp stall data", sol.sol_data_o, exp_sol[k]);
            step();
         end
         check("bp accept data", sol.sol_data_o, exp_sol[k]);
         sol.sol_ready_i = 1'b1;
         step();
         sol.sol_ready_i = 1'b0;
      end
      check("bp done", done_o, 1'b1);
      check("bp hits", hits_o, 2);
      check("bp tries", tries_o, 2);
`ifdef CSE_STATS_EN
      check("bp stall cycles", stall_cycles_o, 8);
`endif

      // Abort while a solution is pending
      sat_mode = 1;
      do_start(32'h3, 3, 10);
      n = 0;
      while (!sol.sol_valid_o && n < 20) begin step(); n++; end
      check("abort valid seen", sol.sol_valid_o, 1'b1);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check("abort valid", sol.sol_valid_o, 1'b0);
      check("abort busy", busy_o, 1'b0);
      check("abort done", done_o, 1'b0);
      check("abort hits", hits_o, 0);
      check("abort tries", tries_o, 1);
      model_run(32'h3, 1, 4, 1);
      do_start(32'h3, 1, 4);
      run_checked("after abort", 0, 100, cyc);

      // Reset in FILL right after a handshake
      sat_mode = 1;
      do_start(32'hB, 3, 5);
      sol.sol_ready_i = 1'b1;
      n = 0;
      while (hits_o != 1 && n < 30) begin step(); n++; end
      sol.sol_ready_i = 1'b0;
      check("rst run hits", hits_o, 1);
      check("rst run busy", busy_o, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrun rst cand", cand_o, 64'h0);
      check("midrun rst hits", hits_o, 0);
      check("midrun rst tries", tries_o, 0);
      check("midrun rst valid", sol.sol_valid_o, 1'b0);
      check("midrun rst busy", busy_o, 1'b0);
      check("midrun rst done", done_o, 1'b0);

      // start_i during CHECK must not recapture target/budget
      sat_mode = 0;
      model_run(32'h21, 3, 2, 0);
      do_start(32'h21, 3, 2);
      for (int j = 0; j < NW; j++) step();
      seed_i = 32'h0; target_i = '0; max_tries_i = 9; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("ignored start busy", busy_o, 1'b1);
      run_checked("ignored start", 0, 100, cyc);

      for (int r = 0; r < 20; r++) begin
         logic [31:0] sd;
         int          tg;
         int          bg;
         sd = $urandom;
         tg = $urandom_range(1, 3);
         bg = $urandom_range(1, 6);
         sat_mode = 2;
         model_run(sd, tg, bg, 2);
         do_start(sd, tg, bg);
         run_checked($sformatf("rand%0d", r), 1, 2000, cyc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
